// File: rtl/instr_decode_pkg.sv
// Shared types for the instruction decoder: instruction layout, opcodes, FSM states.
// Instruction word: [15:12] opcode, [11:8] A, [7:4] B, [3:0] C.
package instr_decode_pkg;

  localparam int INSTR_W     = 16;
  localparam int OPC_W       = 4;
  localparam int FIELD_W     = 4;
  localparam int ADDR_W      = 4;
  localparam int EX_OP_W     = 3;
  localparam int INSTR_DEPTH = 16;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 4'h0,
    OP_BR   = 4'h1,
    OP_LOOP = 4'h2,
    OP_HALT = 4'h3,
    OP_RSV4 = 4'h4,
    OP_RSV5 = 4'h5,
    OP_RSV6 = 4'h6,
    OP_RSV7 = 4'h7,
    OP_ALU0 = 4'h8,
    OP_ALU1 = 4'h9,
    OP_ALU2 = 4'hA,
    OP_ALU3 = 4'hB,
    OP_ALU4 = 4'hC,
    OP_ALU5 = 4'hD,
    OP_ALU6 = 4'hE,
    OP_ALU7 = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef struct packed {
    opcode_e            opc;
    logic [FIELD_W-1:0] a;
    logic [FIELD_W-1:0] b;
    logic [FIELD_W-1:0] c;
  } instr_t;

  // Upper half of the opcode space is the ALU group; 4-7 are reserved.
  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return opc[3];
  endfunction

  function automatic logic is_reserved(input logic [OPC_W-1:0] opc);
    return opc[3:2] == 2'b01;
  endfunction

endpackage

// File: rtl/instr_decode_mem.sv
// 16x16 instruction store: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives rst.
module instr_mem
  import instr_decode_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [INSTR_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_decode.sv
// Instruction decoder: LOAD/RUN/HALT sequencer with zero-latency PC control
// outputs decoded from mem[pc] and a one-cycle registered ALU issue stage.
module instr_decode
  import instr_decode_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc,
  output logic               branch_en,
  output logic [ADDR_W-1:0]  target_address,
  output logic               loop_en,
  output logic [FIELD_W-1:0] repetation_count,
  output logic [FIELD_W-1:0] line_count,
  output logic               ex_valid,
  output logic [EX_OP_W-1:0] ex_op,
  output logic [FIELD_W-1:0] ex_rd,
  output logic [FIELD_W-1:0] ex_rs1,
  output logic [FIELD_W-1:0] ex_rs2,
  output logic               halted,
  output logic               illegal,
  output state_e             state_dbg
);

  state_e             state_q;
  state_e             state_d;
  logic [INSTR_W-1:0] rd_data;
  instr_t             instr;
  logic [OPC_W-1:0]   opc_bits;
  logic               mem_we;
  logic               alu_fire;
  logic               illegal_set;

  // Program writes are only honoured while loading.
  assign mem_we = prog_we && (state_q == ST_LOAD);

  instr_mem u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (rd_data)
  );

  assign instr     = instr_t'(rd_data);
  assign opc_bits  = instr.opc;
  assign state_dbg = state_q;

  // Next state and zero-latency decode. A reset cycle decodes as LOAD so the
  // PC is pulled to 0 before the state register has actually moved.
  always_comb begin
    state_d          = state_q;
    branch_en        = 1'b0;
    target_address   = '0;
    loop_en          = 1'b0;
    repetation_count = '0;
    line_count       = '0;
    halted           = 1'b0;
    alu_fire         = 1'b0;
    illegal_set      = 1'b0;
    if (rst) begin
      branch_en = 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          branch_en = 1'b1;
          if (start) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          case (instr.opc)
            OP_NOP: ;
            OP_BR: begin
              branch_en      = 1'b1;
              target_address = instr.c;
            end
            OP_LOOP: begin
              // A zero repeat count or zero body length is a no-op loop.
              if ((instr.a != '0) && (instr.b != '0)) begin
                loop_en          = 1'b1;
                repetation_count = instr.a;
                line_count       = instr.b;
              end
            end
            OP_HALT: begin
              branch_en      = 1'b1;
              target_address = pc;
              state_d        = ST_HALT;
            end
            default: begin
              alu_fire    = is_alu(opc_bits);
              illegal_set = is_reserved(opc_bits);
            end
          endcase
        end
        ST_HALT: begin
          branch_en      = 1'b1;
          target_address = pc;
          halted         = 1'b1;
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // ex_valid is a single-cycle qualifier for ex_op/ex_rd/ex_rs1/ex_rs2: the
  // fields are meaningful only while ex_valid is high, there is no ready and
  // no backpressure, and the fields hold their last value when ex_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_LOAD;
      ex_valid <= 1'b0;
      ex_op    <= '0;
      ex_rd    <= '0;
      ex_rs1   <= '0;
      ex_rs2   <= '0;
      illegal  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_valid <= alu_fire;
      if (alu_fire) begin
        ex_op  <= opc_bits[EX_OP_W-1:0];
        ex_rd  <= instr.a;
        ex_rs1 <= instr.b;
        ex_rs2 <= instr.c;
      end
      if (illegal_set) begin
        illegal <= 1'b1;
      end
    end
  end

endmodule
